// File: rtl/stack_ctrl.sv
// Stack sequencer: turns PUSH/POP/PEEK requests into pointer inc/dec strobes and
// single-port RAM cycles for a stack whose pointer addresses the next free slot.
module stack_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] push_data,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic              full,
  input  logic [ADDR_W-1:0] sp_val,
  output logic              sp_inc,
  output logic              sp_dec,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state   | meaning
  // IDLE    | waiting for req; only state where req is sampled
  // PUSH_WR | write latched data at sp_val, decrement pointer
  // POP_INC | increment pointer so RD sees the occupied slot
  // RD      | issue RAM read (POP: sp_val, PEEK: sp_val+1)
  // CAP     | capture RAM read data into pop_data
  // DONE    | one-cycle ack, err qualifies it
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH_WR = 3'd1,
    POP_INC = 3'd2,
    RD      = 3'd3,
    CAP     = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_PEEK = 2'b11;

  state_t            state, state_nx;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              err_d;

  assign empty = (sp_val == {ADDR_W{1'b1}});
  assign full  = (sp_val == '0);

  always_comb begin
    err_d = 1'b0;
    case (op)
      OP_PUSH: err_d = full;
      OP_POP,
      OP_PEEK: err_d = empty;
      default: err_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= OP_NOP;
      data_q   <= '0;
      err_q    <= 1'b0;
      pop_data <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        op_q   <= op;
        data_q <= push_data;
        err_q  <= err_d;
      end
      if (state == CAP) pop_data <= mem_rdata;
    end
  end

  // Outputs are decoded from state so an async reset drops every strobe at once.
  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    ack       = 1'b0;
    err       = 1'b0;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (err_d || op == OP_NOP) state_nx = DONE;
          else if (op == OP_PUSH)    state_nx = PUSH_WR;
          else if (op == OP_POP)     state_nx = POP_INC;
          else                       state_nx = RD;
        end
      end
      PUSH_WR: begin
        mem_addr  = sp_val;
        mem_we    = 1'b1;
        mem_wdata = data_q;
        sp_dec    = 1'b1;
        state_nx  = DONE;
      end
      POP_INC: begin
        sp_inc   = 1'b1;
        state_nx = RD;
      end
      RD: begin
        mem_re   = 1'b1;
        mem_addr = (op_q == OP_PEEK) ? sp_val + ADDR_W'(1) : sp_val;
        state_nx = CAP;
      end
      CAP: state_nx = DONE;
      DONE: begin
        ack      = 1'b1;
        err      = err_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: pointer register and RAM models around the DUT, a
// scoreboard of expected completions, vector table plus hand-written corner cases.
module tb_stack_ctrl;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [DW-1:0] push_data = '0;
  logic          busy, ack, err, empty, full;
  logic [DW-1:0] pop_data;
  logic [AW-1:0] sp_val;
  logic          sp_inc, sp_dec;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stack_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .push_data(push_data),
    .busy(busy), .ack(ack), .err(err), .pop_data(pop_data),
    .empty(empty), .full(full), .sp_val(sp_val), .sp_inc(sp_inc), .sp_dec(sp_dec),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Environment: stack pointer register and synchronous-read RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sp_val <= '1;
    else if (sp_inc) sp_val <= sp_val + 10'd1;
    else if (sp_dec) sp_val <= sp_val - 10'd1;
  end

  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int we_cnt = 0;
  int strb_cnt = 0;
  int ack_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((sp_inc && sp_dec) || (mem_we && mem_re)) begin
        failures++;
        $display("FAIL invariant inc=%0b dec=%0b we=%0b re=%0b required no overlap",
                 sp_inc, sp_dec, mem_we, mem_re);
      end
      if (mem_we) we_cnt++;
      if (sp_inc || sp_dec) strb_cnt++;
      if (ack) ack_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    int            lat;
    logic [AW-1:0] sp;
  } exp_t;

  exp_t sbq[$];

  task automatic do_op(input logic [1:0] o, input logic [DW-1:0] d, input logic e_err,
                       input logic [DW-1:0] e_data, input int e_lat, input logic [AW-1:0] e_sp);
    exp_t e, got;
    int lat;
    int s0;
    e.err = e_err; e.data = e_data; e.lat = e_lat; e.sp = e_sp;
    @(negedge clk);
    chk("ack_idle", {31'd0, ack}, 32'd0);
    req = 1'b1; op = o; push_data = d;
    sbq.push_back(e);
    s0 = strb_cnt;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack) begin lat = k; break; end
    end
    got = sbq.pop_front();
    if (lat == 0) begin
      failures++; checks++;
      $display("FAIL ack_timeout op=%0d actual=none required=%0d cycles", o, got.lat);
    end else begin
      chk("lat", lat, got.lat);
      chk("err", {31'd0, err}, {31'd0, got.err});
      chk("pop_data", {16'd0, pop_data}, {16'd0, got.data});
      chk("sp", {22'd0, sp_val}, {22'd0, got.sp});
      chk("strobes", strb_cnt - s0, (got.err || o == 2'b00 || o == 2'b11) ? 0 : 1);
    end
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] data;
    logic          err;
    logic [DW-1:0] rd;
    int            lat;
    logic [AW-1:0] sp;
  } vec_t;

  vec_t vt [11];
  int   w0;
  int   a0;

  initial begin
    vt[0]  = '{2'd2, 16'h0000, 1'b1, 16'hBEEF, 1, 10'h3FF};
    vt[1]  = '{2'd3, 16'h0000, 1'b1, 16'hBEEF, 1, 10'h3FF};
    vt[2]  = '{2'd0, 16'h0000, 1'b0, 16'hBEEF, 1, 10'h3FF};
    vt[3]  = '{2'd1, 16'h1234, 1'b0, 16'hBEEF, 2, 10'h3FE};
    vt[4]  = '{2'd1, 16'h5678, 1'b0, 16'hBEEF, 2, 10'h3FD};
    vt[5]  = '{2'd3, 16'h0000, 1'b0, 16'h5678, 3, 10'h3FD};
    vt[6]  = '{2'd2, 16'h0000, 1'b0, 16'h5678, 4, 10'h3FE};
    vt[7]  = '{2'd3, 16'h0000, 1'b0, 16'h1234, 3, 10'h3FE};
    vt[8]  = '{2'd0, 16'h0000, 1'b0, 16'h1234, 1, 10'h3FE};
    vt[9]  = '{2'd2, 16'h0000, 1'b0, 16'h1234, 4, 10'h3FF};
    vt[10] = '{2'd2, 16'h0000, 1'b1, 16'h1234, 1, 10'h3FF};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_strobes", {28'd0, sp_inc, sp_dec, mem_we, mem_re}, 32'd0);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_pop_data", {16'd0, pop_data}, 32'd0);
    rst_n = 1'b1;

    // PUSH 0xBEEF cycle by cycle
    @(negedge clk);
    req = 1'b1; op = 2'd1; push_data = 16'hBEEF;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    chk("push_we", {31'd0, mem_we}, 32'd1);
    chk("push_addr", {22'd0, mem_addr}, 32'h3FF);
    chk("push_wdata", {16'd0, mem_wdata}, 32'hBEEF);
    chk("push_dec", {30'd0, sp_dec, sp_inc}, 32'd2);
    chk("push_ack1", {31'd0, ack}, 32'd0);
    @(negedge clk);
    chk("push_ack2", {30'd0, ack, err}, 32'd2);
    chk("push_sp", {22'd0, sp_val}, 32'h3FE);

    // POP cycle by cycle
    @(negedge clk);
    req = 1'b1; op = 2'd2;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    chk("pop_inc", {29'd0, sp_inc, sp_dec, mem_re}, 32'd4);
    @(negedge clk);
    chk("pop_re", {30'd0, mem_re, sp_inc}, 32'd2);
    chk("pop_addr", {22'd0, mem_addr}, 32'h3FF);
    @(negedge clk);
    chk("pop_ack3", {30'd0, ack, busy}, 32'd1);
    @(negedge clk);
    chk("pop_ack4", {30'd0, ack, err}, 32'd2);
    chk("pop_data4", {16'd0, pop_data}, 32'hBEEF);
    chk("pop_sp", {22'd0, sp_val}, 32'h3FF);

    // Vector table
    for (int i = 0; i < 11; i++)
      do_op(vt[i].op, vt[i].data, vt[i].err, vt[i].rd, vt[i].lat, vt[i].sp);

    // Fill to capacity, then overflow and PEEK at the top
    for (int i = 0; i < 1023; i++)
      do_op(2'd1, 16'(i), 1'b0, 16'h1234, 2, 10'(10'h3FE - i));
    @(negedge clk);
    chk("fill_full", {30'd0, full, empty}, 32'd2);
    w0 = we_cnt;
    do_op(2'd1, 16'hFFFF, 1'b1, 16'h1234, 1, 10'h000);
    chk("ovf_no_we", we_cnt - w0, 0);
    do_op(2'd3, 16'h0000, 1'b0, 16'h03FE, 3, 10'h000);

    // Reset during RD of a POP
    @(negedge clk);
    req = 1'b1; op = 2'd2;
    @(posedge clk); #1 req = 1'b0;
    a0 = ack_cnt;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_re) break;
    end
    chk("rd_reached", {31'd0, mem_re}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_strobes", {28'd0, sp_inc, sp_dec, mem_we, mem_re}, 32'd0);
    chk("abort_busy", {30'd0, busy, ack}, 32'd0);
    chk("abort_pop_data", {16'd0, pop_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_ack", ack_cnt - a0, 0);
    do_op(2'd1, 16'h1357, 1'b0, 16'h0000, 2, 10'h3FE);
    do_op(2'd3, 16'h0000, 1'b0, 16'h1357, 3, 10'h3FE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=hung required=finish");
    $fatal(1);
  end

endmodule
